histo_readout: RTL

//  Downstream of the pulse-timing/histogram stage: captures its NCHAN 32-bit phase-bin histogram counters
//  on host command and streams them out byte-wise over a valid/ready byte link (UART tx side).

---
 rtl/histo_pkg.sv | 24 ++
 rtl/histo_byte_sel.sv | 30 +++
 rtl/histo_readout.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/histo_pkg.sv
// -----------------------------------------------------------------------------
// histo_pkg
//   Shared constants and types for the histogram readout block.
//   - HISTO_W       : width of one histogram counter
//   - CMD_BYTE_*    : default host command byte values
//   - state_t       : readout FSM state encoding
// -----------------------------------------------------------------------------
package histo_pkg;

    localparam int HISTO_W = 32;

    localparam logic [7:0] CMD_BYTE_READ  = 8'h02;
    localparam logic [7:0] CMD_BYTE_CLEAR = 8'h03;
    localparam logic [7:0] CMD_BYTE_RDCLR = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SEND,
        ST_CSUM,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/histo_byte_sel.sv
// -----------------------------------------------------------------------------
// histo_byte_sel
//   Combinational byte mux over the snapshot registers. Byte i of the frame is
//   snap[8i+7:8i], i.e. counters in channel order, each little-endian.
//   An index beyond the last byte yields 8'h00.
// Ports:
//   snap  in  NCHAN*HISTO_W   captured counters
//   idx   in  IW              byte index
//   data  out 8               selected byte
// -----------------------------------------------------------------------------
module histo_byte_sel
    import histo_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int NBYTES = NCHAN * (HISTO_W / 8),
    parameter int IW = $clog2(NBYTES)
) (
    input  logic [NCHAN*HISTO_W-1:0] snap,
    input  logic [IW-1:0]            idx,
    output logic [7:0]               data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == i[IW-1:0]) data = snap[i*8 +: 8];
        end
    end

endmodule

// File: rtl/histo_readout.sv
// -----------------------------------------------------------------------------
// histo_readout
//   Captures NCHAN 32-bit histogram counters on a host command and streams them
//   out byte-wise over a valid/ready link; also drives the resethist clear
//   pulse back to the histogram stage. Single clock domain (clkin).
//
//   Commands: CMD_READ  -> snapshot + send
//             CMD_CLEAR -> clear pulse only
//             CMD_RDCLR -> snapshot + send, then clear pulse
//   Commands arriving while busy, and unknown bytes, are dropped.
//
//   Build option: HISTO_READOUT_CSUM_EN appends one XOR checksum byte over all
//   data bytes to every frame.
//
// Ports:
//   clkin     in   1              clock
//   nrst      in   1              synchronous active-low reset
//   rx_valid  in   1              command byte strobe
//   rx_data   in   8              command byte
//   histo_in  in   NCHAN*32       live counters, chan k at [32k+31:32k]
//   tx_data   out  8              outgoing byte
//   tx_valid  out  1              tx_data valid, held until tx_ready
//   tx_ready  in   1              sink ready
//   resethist out  1              histogram clear request
//   busy      out  1              high whenever not idle
// -----------------------------------------------------------------------------
module histo_readout
    import histo_pkg::*;
#(
    parameter int         NCHAN      = 4,
    parameter logic [7:0] CMD_READ   = CMD_BYTE_READ,
    parameter logic [7:0] CMD_CLEAR  = CMD_BYTE_CLEAR,
    parameter logic [7:0] CMD_RDCLR  = CMD_BYTE_RDCLR,
    parameter int         CLR_CYCLES = 4
) (
    input  logic                     clkin,
    input  logic                     nrst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic [NCHAN*HISTO_W-1:0] histo_in,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     resethist,
    output logic                     busy
);

    localparam int NBYTES = NCHAN * (HISTO_W / 8);
    localparam int IW     = $clog2(NBYTES);
    localparam int CW     = $clog2(CLR_CYCLES);

    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    state_t                   state;
    logic [NCHAN*HISTO_W-1:0] snapshot;
    logic [IW-1:0]            idx;       // index of the byte currently presented
    logic [IW-1:0]            sel_idx;
    logic [7:0]               sel_byte;
    logic [CW-1:0]            clr_cnt;
    logic                     do_clr;    // frame was started by CMD_RDCLR
    logic                     hs;
`ifdef HISTO_READOUT_CSUM_EN
    logic [7:0]               csum;      // XOR of bytes accepted so far
`endif

    assign hs = tx_valid && tx_ready;

    // While a byte is on the link the mux looks one ahead, so the next byte
    // can be loaded on the same edge as the handshake. Before the first byte
    // is presented tx_valid is low and the mux points at byte 0.
    assign sel_idx = tx_valid ? idx + 1'b1 : idx;

    histo_byte_sel #(
        .NCHAN (NCHAN)
    ) u_byte_sel (
        .snap (snapshot),
        .idx  (sel_idx),
        .data (sel_byte)
    );

    always_ff @(posedge clkin) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            snapshot  <= '0;
            idx       <= '0;
            clr_cnt   <= '0;
            do_clr    <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            resethist <= 1'b0;
            busy      <= 1'b0;
`ifdef HISTO_READOUT_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_READ || rx_data == CMD_RDCLR) begin
                            state  <= ST_SNAP;
                            busy   <= 1'b1;
                            do_clr <= (rx_data == CMD_RDCLR);
                        end else if (rx_data == CMD_CLEAR) begin
                            state     <= ST_CLEAR;
                            busy      <= 1'b1;
                            resethist <= 1'b1;
                            clr_cnt   <= '0;
                        end
                    end
                end

                ST_SNAP: begin
                    snapshot <= histo_in;
                    idx      <= '0;
                    state    <= ST_SEND;
`ifdef HISTO_READOUT_CSUM_EN
                    csum     <= '0;
`endif
                end

                ST_SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= sel_byte;
                    end else if (hs) begin
`ifdef HISTO_READOUT_CSUM_EN
                        csum <= csum ^ tx_data;
`endif
                        if (idx == LAST_IDX) begin
                            idx <= '0;
`ifdef HISTO_READOUT_CSUM_EN
                            // checksum byte includes the byte just accepted
                            state   <= ST_CSUM;
                            tx_data <= csum ^ tx_data;
`else
                            tx_valid <= 1'b0;
                            if (do_clr) begin
                                state     <= ST_CLEAR;
                                resethist <= 1'b1;
                                clr_cnt   <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
`endif
                        end else begin
                            idx     <= idx + 1'b1;
                            tx_data <= sel_byte;
                        end
                    end
                end

`ifdef HISTO_READOUT_CSUM_EN
                ST_CSUM: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        if (do_clr) begin
                            state     <= ST_CLEAR;
                            resethist <= 1'b1;
                            clr_cnt   <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif

                ST_CLEAR: begin
                    // resethist was raised on entry; drop it after CLR_CYCLES
                    if (clr_cnt == CLR_LAST) begin
                        resethist <= 1'b0;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    tx_valid  <= 1'b0;
                    resethist <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
